// File: rtl/exe_stage.sv
// Execute stage: Val2 shifter, ALU with NZCV status register, branch target adder,
// and the EXE/MEM pipeline register feeding the memory stage.
module exe_stage #(
    parameter int ADDRESS_LEN = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic [ADDRESS_LEN-1:0] pc_in,
    input  logic [ADDRESS_LEN-1:0] val_rn,
    input  logic [ADDRESS_LEN-1:0] val_rm,
    input  logic                   immediate,
    input  logic [11:0]            shift_operand,
    input  logic [23:0]            signed_imm24,
    input  logic [3:0]             exe_cmd,
    input  logic                   s,
    input  logic                   b,
    input  logic                   mem_r_en,
    input  logic                   mem_w_en,
    input  logic                   wb_en,
    input  logic [3:0]             dst,
    output logic                   branch_taken,
    output logic [ADDRESS_LEN-1:0] branch_addr,
    output logic [3:0]             status_out,
    output logic [ADDRESS_LEN-1:0] alu_res_out,
    output logic [ADDRESS_LEN-1:0] val_rm_out,
    output logic [3:0]             dst_out,
    output logic                   wb_en_out,
    output logic                   mem_r_en_out,
    output logic                   mem_w_en_out
);

    localparam logic [3:0] OP_MOV = 4'b0001;
    localparam logic [3:0] OP_MVN = 4'b1001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_ADC = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SBC = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_ORR = 4'b0111;
    localparam logic [3:0] OP_EOR = 4'b1000;
    localparam int         MSB    = ADDRESS_LEN - 1;

    function automatic logic [ADDRESS_LEN-1:0] rotr(input logic [ADDRESS_LEN-1:0] v,
                                                    input logic [4:0] amt);
        return (v >> amt) | (v << (ADDRESS_LEN - 32'(amt)));
    endfunction

    function automatic logic [ADDRESS_LEN-1:0] shift_val(input logic [ADDRESS_LEN-1:0] v,
                                                         input logic [4:0] amt,
                                                         input logic [1:0] typ);
        logic signed [ADDRESS_LEN-1:0] v_s;
        v_s = $signed(v);
        case (typ)
            2'b00:   return v << amt;
            2'b01:   return v >> amt;
            2'b10:   return $unsigned(v_s >>> amt);
            default: return rotr(v, amt);
        endcase
    endfunction

    function automatic logic add_ovf(input logic a, input logic bb, input logic r);
        return (a == bb) && (r != a);
    endfunction

    function automatic logic sub_ovf(input logic a, input logic bb, input logic r);
        return (a != bb) && (r != a);
    endfunction

    logic [ADDRESS_LEN-1:0] val2;
    logic [ADDRESS_LEN:0]   sum;
    logic [ADDRESS_LEN-1:0] alu_res;
    logic                   c_new;
    logic                   v_new;
    logic                   op_valid;
    logic [3:0]             status_next;
    logic [ADDRESS_LEN-1:0] imm_sext;
    logic                   c_in;

    logic [3:0]             status_p1;
    logic [ADDRESS_LEN-1:0] alu_res_p1;
    logic [ADDRESS_LEN-1:0] val_rm_p1;
    logic [3:0]             dst_p1;
    logic                   wb_en_p1;
    logic                   mem_r_en_p1;
    logic                   mem_w_en_p1;

    assign c_in = status_p1[1];

    always_comb begin
        if (immediate) begin
            val2 = rotr(ADDRESS_LEN'(shift_operand[7:0]), {shift_operand[11:8], 1'b0});
        end else if (mem_r_en || mem_w_en) begin
            val2 = ADDRESS_LEN'(shift_operand);
        end else begin
            val2 = shift_val(val_rm, shift_operand[11:7], shift_operand[6:5]);
        end
    end

    // Subtraction uses Rn + ~Val2 + carry-in, so bit ADDRESS_LEN is NOT borrow directly.
    always_comb begin
        sum      = '0;
        alu_res  = '0;
        c_new    = status_p1[1];
        v_new    = status_p1[0];
        op_valid = 1'b1;
        case (exe_cmd)
            OP_MOV: alu_res = val2;
            OP_MVN: alu_res = ~val2;
            OP_AND: alu_res = val_rn & val2;
            OP_ORR: alu_res = val_rn | val2;
            OP_EOR: alu_res = val_rn ^ val2;
            OP_ADD, OP_ADC: begin
                sum     = {1'b0, val_rn} + {1'b0, val2}
                          + (ADDRESS_LEN+1)'((exe_cmd == OP_ADC) ? c_in : 1'b0);
                alu_res = sum[ADDRESS_LEN-1:0];
                c_new   = sum[ADDRESS_LEN];
                v_new   = add_ovf(val_rn[MSB], val2[MSB], alu_res[MSB]);
            end
            OP_SUB, OP_SBC: begin
                sum     = {1'b0, val_rn} + {1'b0, ~val2}
                          + (ADDRESS_LEN+1)'((exe_cmd == OP_SBC) ? c_in : 1'b1);
                alu_res = sum[ADDRESS_LEN-1:0];
                c_new   = sum[ADDRESS_LEN];
                v_new   = sub_ovf(val_rn[MSB], val2[MSB], alu_res[MSB]);
            end
            default: op_valid = 1'b0;
        endcase
        status_next = op_valid ? {alu_res[MSB], (alu_res == '0), c_new, v_new} : status_p1;
    end

    assign imm_sext     = {{(ADDRESS_LEN-24){signed_imm24[23]}}, signed_imm24};
    assign branch_addr  = pc_in + (imm_sext << 2);
    assign branch_taken = b;

    // EXE/MEM boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            status_p1   <= '0;
            alu_res_p1  <= '0;
            val_rm_p1   <= '0;
            dst_p1      <= '0;
            wb_en_p1    <= 1'b0;
            mem_r_en_p1 <= 1'b0;
            mem_w_en_p1 <= 1'b0;
        end else if (!freeze) begin
            if (s) begin
                status_p1 <= status_next;
            end
            alu_res_p1  <= alu_res;
            val_rm_p1   <= val_rm;
            dst_p1      <= dst;
            wb_en_p1    <= wb_en;
            mem_r_en_p1 <= mem_r_en;
            mem_w_en_p1 <= mem_w_en;
        end
    end

    assign status_out   = status_p1;
    assign alu_res_out  = alu_res_p1;
    assign val_rm_out   = val_rm_p1;
    assign dst_out      = dst_p1;
    assign wb_en_out    = wb_en_p1;
    assign mem_r_en_out = mem_r_en_p1;
    assign mem_w_en_out = mem_w_en_p1;

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the five-stage ARM pipeline. It consumes the registered ID/EXE bundle, generates the second operand Val2, and runs the ALU. It owns the NZCV status register and computes the branch target. Its results are captured in the EXE/MEM pipeline register that drives the memory stage.

## Interface
- `ADDRESS_LEN`, 32, data/address width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `freeze`  in  1  hazard stall; holds the EXE/MEM register and the status register.
- `pc_in`  in  ADDRESS_LEN  PC+4 of the instruction in EXE.
- `val_rn`, `val_rm`  in  ADDRESS_LEN  register operands.
- `immediate`  in  1  I bit.
- `shift_operand`  in  12  instr[11:0].
- `signed_imm24`  in  24  branch offset, instr[23:0].
- `exe_cmd`  in  4  ALU opcode.
- `s`, `b`, `mem_r_en`, `mem_w_en`, `wb_en`  in  1 each  control bits.
- `dst`  in  4  destination register.
- `branch_taken`  out  1  combinational, equal to `b`.
- `branch_addr`  out  ADDRESS_LEN  combinational branch target.
- `status_out`  out  4  registered {N,Z,C,V}.
- `alu_res_out`, `val_rm_out`  out  ADDRESS_LEN  registered.
- `dst_out`  out  4  registered.
- `wb_en_out`, `mem_r_en_out`, `mem_w_en_out`  out  1 each  registered.

## Operation
- Val2 selection, in priority order:
  - `immediate`=1: zero-extend `shift_operand[7:0]` to 32 bits, then rotate right by 2×`shift_operand[11:8]`.
  - else `mem_r_en`|`mem_w_en`: zero-extend `shift_operand[11:0]`.
  - else: shift `val_rm` by `shift_operand[11:7]` using type `shift_operand[6:5]`:
    - 00 LSL, 01 LSR, 10 ASR, 11 ROR.
    - An amount of 0 passes `val_rm` unchanged for every type.
- ALU opcodes (Cin is the registered C flag):
  - 0001 MOV = Val2
  - 1001 MVN = ~Val2
  - 0010 ADD = Rn+Val2 (also used for LDR/STR address)
  - 0011 ADC = Rn+Val2+Cin
  - 0100 SUB/CMP = Rn−Val2
  - 0101 SBC = Rn−Val2−!Cin
  - 0110 AND/TST
  - 0111 ORR
  - 1000 EOR
  - Any other code yields result 0 with flags unchanged.
- Flag generation:
  - N = res[31]; Z = (res==0).
  - Arithmetic ops: C = bit 32 of a 33-bit add. For SUB/SBC, C = NOT borrow. V = signed overflow.
  - Logical ops (MOV, MVN, AND, ORR, EOR): C and V keep their current values.
- Status register:
  - Loads the new {N,Z,C,V} at the rising edge when `s`=1 and `freeze`=0.
  - Otherwise it holds its value.
- Branch target: `branch_addr` = `pc_in` + (sign-extend(`signed_imm24`) << 2), computed mod 2^32. It is valid every cycle and meaningful only when `b`=1.
- EXE/MEM register:
  - When `freeze`=0, it loads the ALU result, `val_rm`, `dst`, `wb_en`, `mem_r_en` and `mem_w_en` at every edge.
  - When `freeze`=1, it holds all fields.
- Branches are not flushed here; the upstream ID/EXE register guarantees that a branch carries `wb_en`, `mem_r_en` and `mem_w_en` = 0.

## Timing
- Reset: `rst` sampled high at a rising edge sets all registered outputs to 0 (`status_out`=0000, all enables 0). `rst` overrides `freeze`.
- Registered outputs have 1-cycle latency: the instruction presented in cycle n appears on the `*_out` ports after edge n+1.
- `branch_taken` and `branch_addr` have 0-cycle latency. They feed the IF PC mux and the flush logic in the same cycle.
- Flag timing:
  - A flag update is visible on `status_out` one cycle after its instruction.
  - The carry used by an ADC/SBC is the registered C flag, so a flag-setting instruction immediately followed by ADC/SBC uses the new carry.
  - The condition check in ID sees the updated flags in the next cycle.
- Freeze:
  - A `freeze` asserted for k cycles holds all registered outputs and the status register for exactly those k edges.
  - The ALU stays combinational on the current inputs during the freeze.
- Mid-freeze reset: clears all registers; after reset the stage resumes loading from the first edge with `freeze`=0.
- Arithmetic width: everything wraps mod 2^32. Shift amounts are 0–31 and the rotate is 0–30 (even amounts only).

## Test plan
- **ADD then ADC with carry:** reset; ADDS (0010, s=1) Rn=0xFFFFFFFF, imm, Val2=1 → `alu_res_out`=0, `status_out`=0110. Next cycle ADC Rn=5, Rm=3 (LSL #0) → result 9.
- **Immediate rotate:** MOVS with immediate=1, `shift_operand`=0x4FF → Val2=0xFF000000, `alu_res_out`=0xFF000000, N=1, Z=0.
- **Subtract flags:**
  - SUBS 0x80000000−1 → 0x7FFFFFFF, NZCV=0011.
  - CMP 5,5 → NZCV=0110.
  - SUB with s=0 → flags unchanged.
- **Shifter and memory offset:**
  - Rm=0x80000000 with ASR #4 → Val2=0xF8000000.
  - Rm=0x80000000 with ROR #4 → Val2=0x08000000.
  - LDR (`mem_r_en`=1) with `shift_operand`=0xFFC, Rn=0x100 → `alu_res_out`=0x10FC, `mem_r_en_out`=1.
- **Branch:** `b`=1, `pc_in`=0x100, `signed_imm24`=0xFFFFFE → `branch_taken`=1 and `branch_addr`=0xF8 in the same cycle. EXE/MEM enables are 0 after the edge.
- **Freeze and reset:**
  - Load ADDS, then hold `freeze` for 3 cycles with changing inputs → outputs and flags unchanged.
  - Assert `rst` together with `freeze` → all outputs 0 at the next edge.
